k423_id_inst_buf: RTL and testbench
===================================

// Module: k423_id_inst_buf
// PURPOSE
// - Instruction buffer between the IF stage and the ID decoder. Decouples fetch from decode.
// - Queues {pc, inst} pairs accepted from IF and presents the oldest to ID with a vld/rdy handshake.
// - Discards all buffered entries on a pipeline clear (branch/exception redirect from PCU).
// PARAMETERS
// - DEPTH   4             number of entries; power of 2, >= 2
// - ADDR_W  `CORE_ADDR_W  pc width (32)
// - INST_W  `CORE_INST_W  instruction width (32)
// PORTS
// - clk_i           in   1       clock
// - rst_n_i         in   1       synchronous active-low reset
// - pcu_clear_id_i  in   1       flush: drop all entries and any incoming push
// - pcu_stall_id_i  in   1       stall: hold head entry, suppress id_stage_vld_o
// - if_stage_vld_i  in   1       IF presents a valid {pc, inst}
// - id_stage_rdy_o  out  1       buffer can accept from IF
// - if_pc_i         in   ADDR_W  pc of the incoming instruction
// - if_inst_i       in   INST_W  incoming instruction
// - id_stage_vld_o  out  1       head entry valid toward the decoder
// - ex_stage_rdy_i  in   1       downstream accepts the head entry
// - id_pc_o         out  ADDR_W  pc of the head entry
// - id_inst_o       out  INST_W  head instruction
// - id_buf_cnt_o    out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
// - Storage: circular array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, natural wrap. cnt register holds 0..DEPTH.
// - Reset (rst_n_i=0 at posedge): wr_ptr=rd_ptr=cnt=0.
//   Outputs after reset: id_stage_vld_o=0, id_stage_rdy_o=1, id_buf_cnt_o=0, id_pc_o=0, id_inst_o=32'h0000_0013 (NOP).
//   Array contents are not reset.
// - push = if_stage_vld_i & id_stage_rdy_o & ~pcu_clear_id_i.
//   pop  = id_stage_vld_o & ex_stage_rdy_i.
// - id_stage_rdy_o = (cnt != DEPTH). Registered state only; no combinational path from ex_stage_rdy_i.
//   When full, IF is not accepted even if a pop occurs in the same cycle.
// - id_stage_vld_o = (cnt != 0) & ~pcu_stall_id_i & ~pcu_clear_id_i.
// - Empty buffer: id_pc_o=0 and id_inst_o=NOP. Otherwise the array head at rd_ptr, read combinationally.
// - Latency: an entry pushed at edge N is visible on the outputs after edge N. No same-cycle bypass.
// - Simultaneous push and pop (cnt between 1 and DEPTH-1): cnt is unchanged and both pointers advance.
// - Clear has priority over everything: next wr_ptr=rd_ptr=cnt=0. The same-cycle push and pop are both discarded.
// - Stall: no pop. Push is still allowed while not full. Head pc/inst stay stable.
// - Reset asserted mid-operation behaves exactly like clear, plus the reset output values above.
// - Assertions:
//   - no push while cnt==DEPTH
//   - no pop while cnt==0
//   - cnt == (wr_ptr - rd_ptr) mod DEPTH, with cnt==DEPTH whenever the pointers are equal and the buffer is not empty
// TESTING
// - Reset, then idle -> vld_o=0, rdy_o=1, cnt=0, id_inst_o=0x00000013.
// - Push pc 0x80000000/0x04/0x08/0x0C with ex_rdy=0 -> cnt=4, rdy_o=0, head pc=0x80000000.
//   A 5th push is held off until a pop.
// - Full buffer, ex_rdy=1 and if_vld=1 for one cycle -> pop 0x80000000, no push, cnt=3, head=0x80000004.
// - Continuous push and pop for 12 cycles -> in-order pcs 0x80000000..0x8000002C, pointers wrap, cnt stays constant.
// - cnt=3 plus push and pop in the clear cycle -> next cnt=0, vld_o=0. Post-clear push of pc 0x80001000 is the first head.
// - Stall with cnt=2 plus push -> vld_o=0, cnt=3, head unchanged. Release -> 3 pops in order.

Source files
------------

// File: rtl/k423_id_inst_buf.sv
// k423_id_inst_buf: IF -> ID instruction buffer.
// Circular queue of {pc, inst} pairs with valid/ready handshake on both sides.
//
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   pcu_clear_id_i        flush all entries, drop the same-cycle push/pop
//   pcu_stall_id_i        hold the head entry, suppress id_stage_vld_o
//   if_stage_vld_i        IF presents {if_pc_i, if_inst_i}
//   id_stage_rdy_o        buffer not full, can accept from IF
//   id_stage_vld_o        head entry valid toward the decoder
//   ex_stage_rdy_i        downstream accepts the head entry
//   id_pc_o, id_inst_o    head entry (0 / NOP when empty)
//   id_buf_cnt_o          occupancy, 0..DEPTH

module k423_id_inst_buf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       pcu_clear_id_i,
    input  logic                       pcu_stall_id_i,
    input  logic                       if_stage_vld_i,
    output logic                       id_stage_rdy_o,
    input  logic [ADDR_W-1:0]          if_pc_i,
    input  logic [INST_W-1:0]          if_inst_i,
    output logic                       id_stage_vld_o,
    input  logic                       ex_stage_rdy_i,
    output logic [ADDR_W-1:0]          id_pc_o,
    output logic [INST_W-1:0]          id_inst_o,
    output logic [$clog2(DEPTH):0]     id_buf_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic             empty;
    logic             push;
    logic             pop;
    entry_t           head;

    // Ready depends on registered occupancy only, so a full buffer
    // refuses IF even when the head is popped in the same cycle.
    assign empty          = (cnt == '0);
    assign id_stage_rdy_o = (cnt != FULL_CNT);
    assign id_stage_vld_o = ~empty & ~pcu_stall_id_i & ~pcu_clear_id_i;

    assign push = if_stage_vld_i & id_stage_rdy_o & ~pcu_clear_id_i;
    assign pop  = id_stage_vld_o & ex_stage_rdy_i;

    assign head         = mem[rd_ptr];
    assign id_pc_o      = empty ? '0 : head.pc;
    assign id_inst_o    = empty ? NOP_INST : head.inst;
    assign id_buf_cnt_o = cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || pcu_clear_id_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; only entries between the pointers are observed.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && push) begin
            mem[wr_ptr] <= '{pc: if_pc_i, inst: if_inst_i};
        end
    end

    a_no_push_full : assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        !(push && cnt == FULL_CNT)
    );

    a_no_pop_empty : assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        !(pop && empty)
    );

    a_cnt_ptr : assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        (cnt[PTR_W-1:0] == PTR_W'(wr_ptr - rd_ptr)) &&
        ((wr_ptr != rd_ptr) || empty || cnt == FULL_CNT)
    );

endmodule

// File: tb/tb_k423_id_inst_buf.sv
// Testbench for k423_id_inst_buf.
// Vector table plus queue scoreboard of accepted {pc, inst} pairs.

module tb_k423_id_inst_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        stall;
    logic        if_vld;
    logic        id_rdy;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_vld;
    logic        ex_rdy;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  cnt;

    always #5 clk = ~clk;

    k423_id_inst_buf #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .pcu_clear_id_i (clear),
        .pcu_stall_id_i (stall),
        .if_stage_vld_i (if_vld),
        .id_stage_rdy_o (id_rdy),
        .if_pc_i        (if_pc),
        .if_inst_i      (if_inst),
        .id_stage_vld_o (id_vld),
        .ex_stage_rdy_i (ex_rdy),
        .id_pc_o        (id_pc),
        .id_inst_o      (id_inst),
        .id_buf_cnt_o   (cnt)
    );

    typedef struct {
        logic        clr;
        logic        stl;
        logic        ifv;
        logic [31:0] pc;
        logic        exr;
        logic        e_vld;
        logic        e_rdy;
        int          e_cnt;
        logic [31:0] e_pc;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] sb_q [$];
    logic [31:0] pop_log [$];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[23:0], 8'h33};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, check against the scoreboard model, update it.
    task automatic cyc(input logic clr, input logic stl, input logic ifv,
                       input logic [31:0] pc, input logic exr);
        logic m_vld;
        logic m_rdy;
        logic m_push;
        logic m_pop;
        int   sz;
        clear   = clr;
        stall   = stl;
        if_vld  = ifv;
        if_pc   = pc;
        if_inst = inst_of(pc);
        ex_rdy  = exr;
        @(negedge clk);
        sz    = sb_q.size();
        m_vld = (sz != 0) && !stl && !clr;
        m_rdy = (sz != 4);
        chk("vld", id_vld, m_vld);
        chk("rdy", id_rdy, m_rdy);
        chk("cnt", cnt, sz);
        if (sz == 0) begin
            chk("pc_empty", id_pc, 32'h0);
            chk("inst_empty", id_inst, 32'h0000_0013);
        end else begin
            chk("head_pc", id_pc, sb_q[0]);
            chk("head_inst", id_inst, inst_of(sb_q[0]));
        end
        m_push = ifv && m_rdy && !clr;
        m_pop  = m_vld && exr;
        if (m_pop) pop_log.push_back(id_pc);
        @(posedge clk);
        #1;
        if (clr) begin
            sb_q.delete();
        end else begin
            if (m_pop) void'(sb_q.pop_front());
            if (m_push) sb_q.push_back(pc);
        end
    endtask

    task automatic idle_chk(input string name, input logic e_vld,
                            input logic e_rdy, input int e_cnt,
                            input logic [31:0] e_pc);
        clear  = 1'b0;
        stall  = 1'b0;
        if_vld = 1'b0;
        ex_rdy = 1'b0;
        #1;
        chk({name, "_vld"}, id_vld, e_vld);
        chk({name, "_rdy"}, id_rdy, e_rdy);
        chk({name, "_cnt"}, cnt, e_cnt);
        chk({name, "_pc"}, id_pc, e_pc);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{0,0,1,32'h8000_0000,0, 0,1,0,32'h0};
        vecs[1] = '{0,0,1,32'h8000_0004,0, 1,1,1,32'h8000_0000};
        vecs[2] = '{0,0,1,32'h8000_0008,0, 1,1,2,32'h8000_0000};
        vecs[3] = '{0,0,1,32'h8000_000C,0, 1,1,3,32'h8000_0000};
        vecs[4] = '{0,0,1,32'h8000_0010,0, 1,0,4,32'h8000_0000};
        vecs[5] = '{0,0,1,32'h8000_0010,1, 1,0,4,32'h8000_0000};
        vecs[6] = '{0,0,0,32'h0,0,         1,1,3,32'h8000_0004};

        rst_n   = 1'b0;
        clear   = 1'b0;
        stall   = 1'b0;
        if_vld  = 1'b0;
        if_pc   = '0;
        if_inst = '0;
        ex_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset / idle
        chk("rst_inst", id_inst, 32'h0000_0013);
        cyc(0, 0, 0, 32'h0, 0);

        // Fill, full hold-off, pop from full without push
        foreach (vecs[i]) begin
            clear  = vecs[i].clr;
            stall  = vecs[i].stl;
            if_vld = vecs[i].ifv;
            ex_rdy = vecs[i].exr;
            #1;
            chk("tbl_vld", id_vld, vecs[i].e_vld);
            chk("tbl_rdy", id_rdy, vecs[i].e_rdy);
            chk("tbl_cnt", cnt, vecs[i].e_cnt);
            chk("tbl_pc", id_pc, vecs[i].e_pc);
            cyc(vecs[i].clr, vecs[i].stl, vecs[i].ifv, vecs[i].pc,
                vecs[i].exr);
        end
        chk("tbl_pop0", pop_log.size(), 1);
        if (pop_log.size() > 0) chk("tbl_pop_pc", pop_log[0], 32'h8000_0000);

        // Continuous push + pop with pointer wrap
        cyc(1, 0, 0, 32'h0, 0);
        pop_log.delete();
        cyc(0, 0, 1, 32'h8000_0000, 0);
        for (int i = 1; i <= 12; i++) begin
            cyc(0, 0, 1, 32'h8000_0000 + 32'(4 * i), 1);
        end
        chk("stream_n", pop_log.size(), 12);
        for (int i = 0; i < 12 && i < pop_log.size(); i++) begin
            chk("stream_pc", pop_log[i], 32'h8000_0000 + 32'(4 * i));
        end
        idle_chk("stream_end", 1, 1, 1, 32'h8000_0030);

        // Clear with push and pop in the same cycle
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 0, 1, 32'h8000_0100, 0);
        cyc(0, 0, 1, 32'h8000_0104, 0);
        cyc(0, 0, 1, 32'h8000_0108, 0);
        idle_chk("pre_clr", 1, 1, 3, 32'h8000_0100);
        cyc(1, 0, 1, 32'h8000_010C, 1);
        idle_chk("post_clr", 0, 1, 0, 32'h0);
        cyc(0, 0, 1, 32'h8000_1000, 0);
        idle_chk("clr_head", 1, 1, 1, 32'h8000_1000);

        // Stall with push, then release
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 0, 1, 32'h8000_2000, 0);
        cyc(0, 0, 1, 32'h8000_2004, 0);
        cyc(0, 1, 1, 32'h8000_2008, 1);
        clear  = 1'b0;
        stall  = 1'b1;
        if_vld = 1'b0;
        ex_rdy = 1'b1;
        #1;
        chk("stall_vld", id_vld, 1'b0);
        chk("stall_cnt", cnt, 3);
        chk("stall_pc", id_pc, 32'h8000_2000);
        pop_log.delete();
        repeat (3) cyc(0, 0, 0, 32'h0, 1);
        chk("rel_n", pop_log.size(), 3);
        for (int i = 0; i < 3 && i < pop_log.size(); i++) begin
            chk("rel_pc", pop_log[i], 32'h8000_2000 + 32'(4 * i));
        end
        idle_chk("drained", 0, 1, 0, 32'h0);

        // Reset mid-operation
        cyc(0, 0, 1, 32'h8000_3000, 0);
        cyc(0, 0, 1, 32'h8000_3004, 0);
        rst_n  = 1'b0;
        if_vld = 1'b1;
        if_pc  = 32'h8000_3008;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        idle_chk("mid_rst", 0, 1, 0, 32'h0);
        chk("mid_rst_inst", id_inst, 32'h0000_0013);
        cyc(0, 0, 1, 32'h8000_4000, 0);
        cyc(0, 0, 0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
